auv_regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the auv_cpu decode/issue stage.
//  - Sizing: NRD read ports, NWR write ports, NREGS x XLEN storage.
//  - Register 0 reads as zero.
//  - Reads: registered, with same-cycle write bypass and stall-hold.
//  - Stall-hold snoops writebacks so held operands never go stale.
//  - Optional scoreboard of pending writes, reported per read port.

---
 rtl/auv_pkg.sv | 13 +
 rtl/auv_regfile_fwd.sv | 28 ++
 rtl/auv_regfile_mp.sv | 115 +++++++++++
 tb/tb_auv_regfile_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/auv_pkg.sv
// Shared types and default sizing for the auv_cpu integer register file.
package auv_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 16;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_XLEN-1:0] word_t;
  typedef logic [DEF_AW-1:0]   reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/auv_regfile_fwd.sv
// Write-port forwarding match: reports whether any enabled write port targets
// addr and returns the data of the highest-index such port.
module auv_regfile_fwd #(
  parameter int XLEN = 32,
  parameter int AW   = 4,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]   addr,
  input  logic            we [NWR],
  input  logic [AW-1:0]   wa [NWR],
  input  logic [XLEN-1:0] wd [NWR],
  output logic            hit,
  output logic [XLEN-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan so the highest matching port is the one left standing.
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && (wa[j] == addr)) begin
        hit  = 1'b1;
        data = wd[j];
      end
    end
  end

endmodule

// File: rtl/auv_regfile_mp.sv
// Multi-port integer register file with registered reads, write bypass and
// snooping stall-hold. Optional pending-write scoreboard: AUV_REGFILE_SCOREBOARD_EN.
module auv_regfile_mp
  import auv_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [AW-1:0]   ra [NRD],
  output logic [XLEN-1:0] rd [NRD],
  input  logic            we [NWR],
  input  logic [AW-1:0]   wa [NWR],
  input  logic [XLEN-1:0] wd [NWR],
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  output logic            busy [NRD]
);

  logic [XLEN-1:0] mem [NREGS];

  // Writes to r0 are dropped, so mem[0] stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) mem[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j] != '0)) mem[wa[j]] <= wd[j];
      end
    end
  end

`ifdef AUV_REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_nxt;

  // Clears from writebacks first, then the issue-side set, so set wins.
  always_comb begin
    sb_nxt = sb;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) sb_nxt[wa[j]] = 1'b0;
    end
    if (sb_set) sb_nxt[sb_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= sb_nxt;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_addr};
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   cap_q;
    logic [XLEN-1:0] rd_q;
    logic [AW-1:0]   fwd_addr;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    // One matcher per port: it watches ra while reading and cap while held.
    assign fwd_addr = stall ? cap_q : ra[i];

    auv_regfile_fwd #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_fwd (
      .addr (fwd_addr),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .hit  (fwd_hit),
      .data (fwd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q  <= '0;
        cap_q <= '0;
      end else if (stall) begin
        if ((cap_q != '0) && fwd_hit) rd_q <= fwd_data;
      end else begin
        cap_q <= ra[i];
        if (ra[i] == '0)  rd_q <= '0;
        else if (fwd_hit) rd_q <= fwd_data;
        else              rd_q <= mem[ra[i]];
      end
    end

    assign rd[i] = rd_q;

`ifdef AUV_REGFILE_SCOREBOARD_EN
    logic busy_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        busy_q <= 1'b0;
      else if (stall) busy_q <= sb_nxt[cap_q];
      else            busy_q <= sb_nxt[ra[i]];
    end

    assign busy[i] = busy_q;
`else
    assign busy[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_auv_regfile_mp.sv
// Self-checking bench for auv_regfile_mp at default sizing (2 read, 2 write ports).
module tb_auv_regfile_mp;

`ifdef AUV_REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic [3:0]  ra [2];
  logic [31:0] rd [2];
  logic        we [2];
  logic [3:0]  wa [2];
  logic [31:0] wd [2];
  logic        sb_set;
  logic [3:0]  sb_addr;
  logic        busy [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          stall;
    bit          we0;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    bit          we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    bit          sbs;
    logic [3:0]  sba;
    logic [31:0] r0;
    logic [31:0] r1;
    bit          b0;
    bit          b1;
  } cyc_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  auv_regfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .ra      (ra),
    .rd      (rd),
    .we      (we),
    .wa      (wa),
    .wd      (wd),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cyc_t c(bit st, bit e0, logic [3:0] a0, logic [31:0] d0,
                             bit e1, logic [3:0] a1, logic [31:0] d1,
                             logic [3:0] r_a0, logic [3:0] r_a1, bit s, logic [3:0] sa,
                             logic [31:0] x0, logic [31:0] x1, bit y0, bit y1);
    cyc_t t;
    t.stall = st; t.we0 = e0; t.wa0 = a0; t.wd0 = d0;
    t.we1 = e1; t.wa1 = a1; t.wd1 = d1; t.ra0 = r_a0; t.ra1 = r_a1;
    t.sbs = s; t.sba = sa; t.r0 = x0; t.r1 = x1; t.b0 = y0; t.b1 = y1;
    return t;
  endfunction

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return rd[0];
      1:       return rd[1];
      2:       return {31'b0, busy[0]};
      default: return {31'b0, busy[1]};
    endcase
  endfunction

  task automatic drive(cyc_t t);
    stall = t.stall;
    we[0] = t.we0; wa[0] = t.wa0; wd[0] = t.wd0;
    we[1] = t.we1; wa[1] = t.wa1; wd[1] = t.wd1;
    ra[0] = t.ra0; ra[1] = t.ra1;
    sb_set = t.sbs; sb_addr = t.sba;
  endtask

  task automatic push(cyc_t t, string tag);
    exp_q.push_back('{{tag, ".rd0"}, 0, t.r0});
    exp_q.push_back('{{tag, ".rd1"}, 1, t.r1});
    exp_q.push_back('{{tag, ".busy0"}, 2, {31'b0, t.b0}});
    exp_q.push_back('{{tag, ".busy1"}, 3, {31'b0, t.b1}});
  endtask

  task automatic test_reset();
    cyc_t t[$];
    exp_t e;
    logic [31:0] o;
    repeat (2) @(posedge clk);
    #1;
    push(c(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0), "reset_hold");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = observe(e.sel); checks++;
      if (o !== e.val) begin
        failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    t.push_back(c(0,0,0,0,0,0,0,3,0,0,0, 0,0,0,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("reset_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_bypass();
    cyc_t t[$];
    exp_t e;
    logic [31:0] o;
    t.push_back(c(0,1,5,32'hAAAA,0,0,0,5,5,0,0, 32'hAAAA,32'hAAAA,0,0));
    t.push_back(c(0,0,3,32'h1234,0,5,32'h5555,5,3,0,0, 32'hAAAA,0,0,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("bypass_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_priority();
    cyc_t t[$];
    exp_t e;
    logic [31:0] o;
    t.push_back(c(0,1,7,32'h1,1,7,32'h2,7,7,0,0, 32'h2,32'h2,0,0));
    t.push_back(c(0,1,8,32'h80,1,9,32'h90,7,5,0,0, 32'h2,32'hAAAA,0,0));
    t.push_back(c(0,0,0,0,0,0,0,8,9,0,0, 32'h80,32'h90,0,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("prio_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_stall();
    cyc_t t[$];
    exp_t e;
    logic [31:0] o;
    t.push_back(c(0,1,4,32'h10,0,0,0,4,7,0,0, 32'h10,32'h2,0,0));
    t.push_back(c(1,0,0,0,0,0,0,2,0,0,0, 32'h10,32'h2,0,0));
    t.push_back(c(1,0,0,0,1,4,32'h99,2,0,0,0, 32'h99,32'h2,0,0));
    t.push_back(c(1,1,6,32'h66,1,7,32'h77,2,0,0,0, 32'h99,32'h77,0,0));
    t.push_back(c(0,0,0,0,0,0,0,4,6,0,0, 32'h99,32'h66,0,0));
    t.push_back(c(0,0,0,0,0,0,0,0,6,0,0, 0,32'h66,0,0));
    t.push_back(c(1,1,0,32'hFFFF,1,6,32'h606,3,3,0,0, 0,32'h606,0,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("stall_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_zero();
    cyc_t t[$];
    exp_t e;
    logic [31:0] o;
    t.push_back(c(0,1,0,32'hFFFF,1,0,32'hEEEE,0,0,0,0, 0,0,0,0));
    t.push_back(c(0,0,0,0,0,0,0,0,4,0,0, 0,32'h99,0,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("zero_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  task automatic test_scoreboard();
    cyc_t t[$];
    cyc_t p[$];
    exp_t e;
    logic [31:0] o;
    t.push_back(c(0,0,0,0,0,0,0,0,0,1,9, 0,0,0,0));
    t.push_back(c(0,0,0,0,0,0,0,9,8,0,0, 32'h90,32'h80,SB,0));
    t.push_back(c(0,1,9,32'h91,0,0,0,9,8,1,9, 32'h91,32'h80,SB,0));
    t.push_back(c(0,0,0,0,1,9,32'h92,9,9,0,0, 32'h92,32'h92,0,0));
    t.push_back(c(1,0,0,0,0,0,0,3,3,1,9, 32'h92,32'h92,SB,SB));
    t.push_back(c(1,0,0,0,0,0,0,3,3,0,0, 32'h92,32'h92,SB,SB));
    t.push_back(c(0,0,0,0,0,0,0,9,2,0,0, 32'h92,0,SB,0));
    foreach (t[k]) begin
      @(negedge clk); drive(t[k]); push(t[k], $sformatf("sb_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
    // Asynchronous reset between edges while a write and a set are in flight.
    @(negedge clk);
    drive(c(0,1,5,32'h5A,0,0,0,9,9,1,5, 0,0,0,0));
    #2 rst = 1'b1;
    #1;
    push(c(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0), "async_rst");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = observe(e.sel); checks++;
      if (o !== e.val) begin
        failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    drive(c(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    rst = 1'b0;
    p.push_back(c(0,0,0,0,0,0,0,5,9,0,0, 0,0,0,0));
    foreach (p[k]) begin
      @(negedge clk); drive(p[k]); push(p[k], $sformatf("post_rst_c%0d", k));
      @(posedge clk); #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); o = observe(e.sel); checks++;
        if (o !== e.val) begin
          failures++; $display("FAIL %s got=%h exp=%h", e.name, o, e.val);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(c(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    test_reset();
    test_bypass();
    test_priority();
    test_stall();
    test_zero();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
